mem_access_initiator: RTL

- Clocked initiator that drives the SNN accelerator's spike/filter/membrane-potential memory protocol from the compute side.
- Accepts one command at a time (read, write, advance timestep) from a PE or controller over a valid/ready command port.
- Sequences the memory's type, x, y, data and T channels in protocol order, bounds-checks coordinates, tracks the current timestep, and returns read data or an error on a response port.

---
 rtl/mem_access_pkg.sv | 36 +++
 rtl/mem_access_initiator_if.sv | 44 ++++
 rtl/mem_bounds_check.sv | 67 ++++++
 rtl/mem_access_initiator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default dimensions for the SNN memory access initiators.
package mem_access_pkg;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        WRITE   = 2'd1,
        ADVANCE = 2'd2,
        RSVD    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        VPOT   = 2'd0,
        SPIKE  = 2'd1,
        FILTER = 2'd2
    } sel_e;

    // Initiator FSM states, kept as plain constants so older blocks can share the encoding.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_TYPE = 3'd1;
    localparam logic [2:0] SEND_XY   = 3'd2;
    localparam logic [2:0] WAIT_DOUT = 3'd3;
    localparam logic [2:0] SEND_DIN  = 3'd4;
    localparam logic [2:0] SEND_T    = 3'd5;
    localparam logic [2:0] RESP      = 3'd6;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_COORD_W   = 4;
    localparam int DEF_TIMESTEPS = 10;
    localparam int DEF_IF_ROWS   = 5;
    localparam int DEF_IF_COLS   = 5;
    localparam int DEF_F_ROWS    = 3;
    localparam int DEF_F_COLS    = 3;
    localparam int DEF_OF_ROWS   = 3;
    localparam int DEF_OF_COLS   = 3;

endpackage

// File: rtl/mem_access_initiator_if.sv
// Memory-side channel bundle: type, x, y, din, dout and timestep handshakes.
interface mem_access_initiator_if #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 4
);
    logic               rd_type_valid;
    logic               rd_type_ready;
    logic [1:0]         rd_type_data;
    logic               wr_type_valid;
    logic               wr_type_ready;
    logic [1:0]         wr_type_data;
    logic               x_valid;
    logic               x_ready;
    logic [COORD_W-1:0] x_data;
    logic               y_valid;
    logic               y_ready;
    logic [COORD_W-1:0] y_data;
    logic               din_valid;
    logic               din_ready;
    logic [DATA_W-1:0]  din_data;
    logic               dout_valid;
    logic               dout_ready;
    logic [DATA_W-1:0]  dout_data;
    logic               t_valid;
    logic               t_ready;
    logic [COORD_W-1:0] t_data;

    modport master (
        output rd_type_valid, rd_type_data, wr_type_valid, wr_type_data,
        output x_valid, x_data, y_valid, y_data, din_valid, din_data,
        output dout_ready, t_valid, t_data,
        input  rd_type_ready, wr_type_ready, x_ready, y_ready, din_ready,
        input  dout_valid, dout_data, t_ready
    );

    modport slave (
        input  rd_type_valid, rd_type_data, wr_type_valid, wr_type_data,
        input  x_valid, x_data, y_valid, y_data, din_valid, din_data,
        input  dout_ready, t_valid, t_data,
        output rd_type_ready, wr_type_ready, x_ready, y_ready, din_ready,
        output dout_valid, dout_data, t_ready
    );

endinterface

// File: rtl/mem_bounds_check.sv
// Combinational legality check for one command against the memory map and timestep state.
module mem_bounds_check
    import mem_access_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int IF_ROWS = DEF_IF_ROWS,
    parameter int IF_COLS = DEF_IF_COLS,
    parameter int F_ROWS  = DEF_F_ROWS,
    parameter int F_COLS  = DEF_F_COLS,
    parameter int OF_ROWS = DEF_OF_ROWS,
    parameter int OF_COLS = DEF_OF_COLS
) (
    input  logic [1:0]         op,
    input  logic [1:0]         sel,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    input  logic               done,
    output logic               err
);

    localparam logic [COORD_W-1:0] IF_R = COORD_W'(IF_ROWS);
    localparam logic [COORD_W-1:0] IF_C = COORD_W'(IF_COLS);
    localparam logic [COORD_W-1:0] F_R  = COORD_W'(F_ROWS);
    localparam logic [COORD_W-1:0] F_C  = COORD_W'(F_COLS);
    localparam logic [COORD_W-1:0] OF_R = COORD_W'(OF_ROWS);
    localparam logic [COORD_W-1:0] OF_C = COORD_W'(OF_COLS);

    logic [COORD_W-1:0] row_lim;
    logic [COORD_W-1:0] col_lim;
    logic               bad_sel;

    // Pick the map dimensions for the selected memory (spikes read the input map, write the output map), then flag illegal commands.
    always_comb begin
        row_lim = OF_R;
        col_lim = OF_C;
        bad_sel = 1'b0;
        case (sel)
            VPOT: begin
                row_lim = OF_R;
                col_lim = OF_C;
            end
            SPIKE: begin
                if (op == READ) begin
                    row_lim = IF_R;
                    col_lim = IF_C;
                end
            end
            FILTER: begin
                row_lim = F_R;
                col_lim = F_C;
            end
            default: bad_sel = 1'b1;
        endcase

        err = 1'b0;
        if (op == RSVD || bad_sel) begin
            err = 1'b1;
        end else if (op == ADVANCE) begin
            err = done;
        end else if (op == WRITE && sel == FILTER) begin
            err = 1'b1;
        end else begin
            err = (row >= row_lim) || (col >= col_lim);
        end
    end

endmodule

// File: rtl/mem_access_initiator.sv
// Compute-side initiator: takes one command, walks the memory channels in protocol order, returns a response.
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int TIMESTEPS = DEF_TIMESTEPS,
    parameter int IF_ROWS   = DEF_IF_ROWS,
    parameter int IF_COLS   = DEF_IF_COLS,
    parameter int F_ROWS    = DEF_F_ROWS,
    parameter int F_COLS    = DEF_F_COLS,
    parameter int OF_ROWS   = DEF_OF_ROWS,
    parameter int OF_COLS   = DEF_OF_COLS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [1:0]             cmd_sel,
    input  logic [COORD_W-1:0]     cmd_row,
    input  logic [COORD_W-1:0]     cmd_col,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    mem_access_initiator_if.master mem,
    output logic [COORD_W-1:0]     t_cur,
    output logic                   done
);

    localparam logic [COORD_W-1:0] T_LAST = COORD_W'(TIMESTEPS);

    logic [2:0]         state;
    logic [1:0]         op_q;
    logic [1:0]         sel_q;
    logic [COORD_W-1:0] row_q;
    logic [COORD_W-1:0] col_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               cmd_err;
    logic               x_fin;
    logic               y_fin;

    mem_bounds_check #(
        .COORD_W (COORD_W),
        .IF_ROWS (IF_ROWS),
        .IF_COLS (IF_COLS),
        .F_ROWS  (F_ROWS),
        .F_COLS  (F_COLS),
        .OF_ROWS (OF_ROWS),
        .OF_COLS (OF_COLS)
    ) u_bounds (
        .op   (cmd_op),
        .sel  (cmd_sel),
        .row  (cmd_row),
        .col  (cmd_col),
        .done (done),
        .err  (cmd_err)
    );

    // x and y retire independently; each is finished once it has transferred or transfers this edge.
    always_comb begin
        x_fin = !mem.x_valid || mem.x_ready;
        y_fin = !mem.y_valid || mem.y_ready;
    end

    // Main sequencer: every channel valid is a register raised one state ahead and dropped on its own transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            op_q              <= 2'd0;
            sel_q             <= 2'd0;
            row_q             <= '0;
            col_q             <= '0;
            wdata_q           <= '0;
            cmd_ready         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_err           <= 1'b0;
            mem.rd_type_valid <= 1'b0;
            mem.rd_type_data  <= 2'd0;
            mem.wr_type_valid <= 1'b0;
            mem.wr_type_data  <= 2'd0;
            mem.x_valid       <= 1'b0;
            mem.x_data        <= '0;
            mem.y_valid       <= 1'b0;
            mem.y_data        <= '0;
            mem.din_valid     <= 1'b0;
            mem.din_data      <= '0;
            mem.dout_ready    <= 1'b0;
            mem.t_valid       <= 1'b0;
            mem.t_data        <= '0;
            t_cur             <= '0;
            done              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        sel_q     <= cmd_sel;
                        row_q     <= cmd_row;
                        col_q     <= cmd_col;
                        wdata_q   <= cmd_wdata;
                        if (cmd_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end else if (cmd_op == ADVANCE) begin
                            mem.t_valid <= 1'b1;
                            mem.t_data  <= t_cur + 1'b1;
                            state       <= SEND_T;
                        end else if (cmd_op == READ) begin
                            mem.rd_type_valid <= 1'b1;
                            mem.rd_type_data  <= cmd_sel;
                            state             <= SEND_TYPE;
                        end else begin
                            mem.wr_type_valid <= 1'b1;
                            mem.wr_type_data  <= cmd_sel;
                            state             <= SEND_TYPE;
                        end
                    end
                end
                SEND_TYPE: begin
                    if ((mem.rd_type_valid && mem.rd_type_ready) ||
                        (mem.wr_type_valid && mem.wr_type_ready)) begin
                        mem.rd_type_valid <= 1'b0;
                        mem.wr_type_valid <= 1'b0;
                        mem.x_valid       <= 1'b1;
                        mem.x_data        <= row_q;
                        mem.y_valid       <= 1'b1;
                        mem.y_data        <= col_q;
                        state             <= SEND_XY;
                    end
                end
                SEND_XY: begin
                    if (mem.x_valid && mem.x_ready) begin
                        mem.x_valid <= 1'b0;
                    end
                    if (mem.y_valid && mem.y_ready) begin
                        mem.y_valid <= 1'b0;
                    end
                    if (x_fin && y_fin) begin
                        if (op_q == READ) begin
                            mem.dout_ready <= 1'b1;
                            state          <= WAIT_DOUT;
                        end else begin
                            mem.din_valid <= 1'b1;
                            mem.din_data  <= (sel_q == SPIKE) ?
                                             {{(DATA_W-1){1'b0}}, wdata_q[0]} : wdata_q;
                            state         <= SEND_DIN;
                        end
                    end
                end
                WAIT_DOUT: begin
                    if (mem.dout_valid && mem.dout_ready) begin
                        mem.dout_ready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_err        <= 1'b0;
                        rsp_data       <= mem.dout_data;
                        state          <= RESP;
                    end
                end
                SEND_DIN: begin
                    if (mem.din_valid && mem.din_ready) begin
                        mem.din_valid <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_err       <= 1'b0;
                        rsp_data      <= '0;
                        state         <= RESP;
                    end
                end
                SEND_T: begin
                    if (mem.t_valid && mem.t_ready) begin
                        mem.t_valid <= 1'b0;
                        t_cur       <= t_cur + 1'b1;
                        if (t_cur + 1'b1 == T_LAST) begin
                            done <= 1'b1;
                        end
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
